// File: rtl/seq_shift_add_mult_pkg.sv
// Shared types and widths for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mult_state_t;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int CNT_W  = 3;

endpackage

// File: rtl/seq_shift_add_mult_if.sv
// Operand/product valid-ready bus of the multiplier, plus its busy flag.
interface seq_shift_add_mult_if;
  import mult_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] product;
  logic              busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface

// File: rtl/seq_shift_add_mult_adder.sv
// 16-bit adder: four 4-bit carry-lookahead groups chained by group generate/propagate.
module _16_bit_fast_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] o
);

  logic [15:0] p;
  logic [14:0] g;
  logic [15:0] c;
  logic [3:0]  gc;

  assign p     = a ^ b;
  assign g     = a[14:0] & b[14:0];
  assign gc[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_grp
      localparam int B = 4 * gi;

      assign c[B]   = gc[gi];
      assign c[B+1] = g[B] | (p[B] & gc[gi]);
      assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[gi]);
      assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & gc[gi]);

      // The carry out of the top group would be bit 16, which the multiplier never needs.
      if (gi < 3) begin : g_la
        assign gc[gi+1] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                        | (p[B+3] & p[B+2] & p[B+1] & g[B])
                        | (&p[B+3:B] & gc[gi]);
      end
    end
  endgenerate

  assign o = p ^ c;

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential 8x8 unsigned shift-and-add multiplier, one partial-product add per cycle.
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int OP_W       = mult_pkg::OP_W,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_shift_add_mult_if.slave  bus
);

  mult_state_t       state_reg, state_next;
  logic [PROD_W-1:0] acc_reg, acc_next;
  logic [PROD_W-1:0] mcand_reg, mcand_next;
  logic [OP_W-1:0]   mplr_reg, mplr_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [PROD_W-1:0] sum;

  _16_bit_fast_adder u_adder (
    .a (acc_reg),
    .b (mcand_reg),
    .o (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      acc_reg   <= '0;
      mcand_reg <= '0;
      mplr_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      mcand_reg <= mcand_next;
      mplr_reg  <= mplr_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    mcand_next = mcand_reg;
    mplr_next  = mplr_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      S_IDLE: begin
        if (bus.in_valid) begin
          mcand_next = {{OP_W{1'b0}}, bus.a};
          mplr_next  = bus.b;
          acc_next   = '0;
          cnt_next   = '0;
          state_next = S_RUN;
        end
      end

      S_RUN: begin
        if (mplr_reg[0]) begin
          acc_next = sum;
        end
        mcand_next = mcand_reg << 1;
        mplr_next  = mplr_reg >> 1;
        cnt_next   = cnt_reg + 1'b1;
        // Stop as soon as no set multiplier bits remain after this step.
        if ((cnt_reg == CNT_W'(OP_W - 1)) ||
            (EARLY_EXIT && (mplr_reg[OP_W-1:1] == '0))) begin
          state_next = S_DONE;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_reg == S_IDLE);
  assign bus.out_valid = (state_reg == S_DONE);
  assign bus.product   = acc_reg;
  assign bus.busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Scenario bench for seq_shift_add_mult: expected products queued at accept, checked at output.
module tb_seq_shift_add_mult;

  typedef struct {
    logic [15:0] prod;
    int          n;
    int          acc_cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  exp_t sb_q[$];

  seq_shift_add_mult_if bus ();
  seq_shift_add_mult_if bus0 ();

  seq_shift_add_mult #(.OP_W(8), .EARLY_EXIT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  seq_shift_add_mult #(.OP_W(8), .EARLY_EXIT(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nsteps(input logic [7:0] b, input bit ee);
    int n;
    if (!ee) return 8;
    n = 1;
    for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   w = 0;
    while (bus.in_ready !== 1'b1 && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    chk_cnt++;
    if (w >= 40) $display("FAIL send_wait in_ready=%b required 1", bus.in_ready);
    else pass_cnt++;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    e.prod    = {8'h00, a} * {8'h00, b};
    e.n       = nsteps(b, 1'b1);
    e.acc_cyc = cyc + 1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit seen, output logic [15:0] prod, output int lat,
                          output exp_t e);
    int w = 0;
    while (bus.out_valid !== 1'b1 && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    seen = (bus.out_valid === 1'b1);
    prod = bus.product;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else begin
      e.prod = 'x; e.n = -1; e.acc_cyc = 0;
    end
    lat = cyc - e.acc_cyc;
  endtask

  task automatic test_reset();
    chk_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", bus.in_ready);
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", bus.out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (bus.product !== 16'h0000) $display("FAIL rst_product got %h exp 0000", bus.product);
    else pass_cnt++;
    chk_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", bus.busy);
    else pass_cnt++;
    chk_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL rst_idle_ready got %b exp 1", bus.in_ready);
    else pass_cnt++;
    $display("reset: done");
  endtask

  task automatic run_single(input string name, input logic [7:0] a, input logic [7:0] b);
    bit          seen;
    logic [15:0] prod;
    int          lat;
    exp_t        e;
    send(a, b);
    chk_cnt++;
    if (bus.busy !== 1'b1) $display("FAIL %s_busy got %b exp 1", name, bus.busy);
    else pass_cnt++;
    wait_out(seen, prod, lat, e);
    chk_cnt++;
    if (!seen) $display("FAIL %s_timeout out_valid=%b required 1", name, bus.out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (prod !== e.prod) $display("FAIL %s_product got %h exp %h", name, prod, e.prod);
    else pass_cnt++;
    chk_cnt++;
    if (lat !== e.n) $display("FAIL %s_latency got %0d exp %0d", name, lat, e.n);
    else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL %s_release in_ready=%b exp 1", name, bus.in_ready);
    else pass_cnt++;
    $display("%s: a=%h b=%h product=%h latency=%0d", name, a, b, prod, lat);
  endtask

  task automatic test_basic();
    run_single("basic_13x11", 8'd13, 8'd11);
  endtask

  task automatic test_max();
    int w = 0;
    int acc;
    run_single("max_ee1", 8'hFF, 8'hFF);
    while (bus0.in_ready !== 1'b1 && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    bus0.a = 8'hFF; bus0.b = 8'hFF; bus0.in_valid = 1'b1;
    acc = cyc + 1;
    @(posedge clk); #1;
    bus0.in_valid = 1'b0;
    w = 0;
    while (bus0.out_valid !== 1'b1 && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    chk_cnt++;
    if (cyc - acc !== 8) $display("FAIL max_ee0_latency got %0d exp 8", cyc - acc);
    else pass_cnt++;
    chk_cnt++;
    if (bus0.product !== 16'hFE01) $display("FAIL max_ee0_product got %h exp fe01", bus0.product);
    else pass_cnt++;
    @(posedge clk); #1;
    $display("max_ee0: product=%h latency=%0d", bus0.product, cyc - 1 - acc);
  endtask

  task automatic test_zero();
    run_single("zero_b", 8'hA5, 8'h00);
    run_single("zero_a", 8'h00, 8'h80);
  endtask

  task automatic test_stall();
    bit          seen;
    logic [15:0] prod;
    int          lat;
    exp_t        e;
    bus.out_ready = 1'b0;
    send(8'd9, 8'd7);
    wait_out(seen, prod, lat, e);
    chk_cnt++;
    if (!seen || prod !== e.prod) $display("FAIL stall_product got %h exp %h", prod, e.prod);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.a = 8'h21; bus.b = 8'h03;
      @(posedge clk); #1;
      chk_cnt++;
      if (bus.out_valid !== 1'b1) $display("FAIL stall_hold_valid got %b exp 1", bus.out_valid);
      else pass_cnt++;
      chk_cnt++;
      if (bus.product !== e.prod) $display("FAIL stall_hold_product got %h exp %h", bus.product, e.prod);
      else pass_cnt++;
      chk_cnt++;
      if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready got %b exp 0", bus.in_ready);
      else pass_cnt++;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL stall_release out_valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready);
    else pass_cnt++;
    e.prod = 16'h0063; e.n = nsteps(8'h03, 1'b1); e.acc_cyc = cyc + 1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out(seen, prod, lat, e);
    chk_cnt++;
    if (!seen || prod !== 16'h0063) $display("FAIL stall_next_product got %h exp 0063", prod);
    else pass_cnt++;
    chk_cnt++;
    if (lat !== e.n) $display("FAIL stall_next_latency got %0d exp %0d", lat, e.n);
    else pass_cnt++;
    @(posedge clk); #1;
    $display("stall: held product=0x3f, next product=%h", prod);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    send(8'd200, 8'd200);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b exp 0", bus.out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (bus.product !== 16'h0000) $display("FAIL midrst_product got %h exp 0000", bus.product);
    else pass_cnt++;
    chk_cnt++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL midrst_idle in_ready=%b busy=%b exp 1/0", bus.in_ready, bus.busy);
    else pass_cnt++;
    sb_q.delete(sb_q.size() - 1);
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset_mid: op dropped");
    run_single("after_rst_3x7", 8'd3, 8'd7);
  endtask

  task automatic test_back_to_back();
    bit          seen;
    logic [15:0] prod;
    int          lat;
    int          stall;
    int          recv = 0;
    exp_t        e;
    logic [7:0]  ra, rb;
    for (int i = 0; i < 2000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      stall = $urandom_range(0, 3);
      bus.out_ready = (stall == 0);
      send(ra, rb);
      wait_out(seen, prod, lat, e);
      if (seen) recv++;
      chk_cnt++;
      if (prod !== e.prod) $display("FAIL b2b_product a=%h b=%h got %h exp %h", ra, rb, prod, e.prod);
      else pass_cnt++;
      chk_cnt++;
      if (lat !== e.n) $display("FAIL b2b_latency b=%h got %0d exp %0d", rb, lat, e.n);
      else pass_cnt++;
      repeat (stall) begin
        @(posedge clk); #1;
      end
      chk_cnt++;
      if (bus.out_valid !== 1'b1 || bus.product !== e.prod)
        $display("FAIL b2b_hold valid=%b product=%h exp 1/%h", bus.out_valid, bus.product, e.prod);
      else pass_cnt++;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk_cnt++;
      if (bus.out_valid !== 1'b0) $display("FAIL b2b_dup out_valid=%b exp 0", bus.out_valid);
      else pass_cnt++;
      if (i % 250 == 0) $display("b2b[%0d]: a=%h b=%h product=%h steps=%0d", i, ra, rb, prod, lat);
    end
    chk_cnt++;
    if (recv !== 2000 || sb_q.size() !== 0)
      $display("FAIL b2b_count received=%0d pending=%0d exp 2000/0", recv, sb_q.size());
    else pass_cnt++;
    $display("back_to_back: received %0d", recv);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.a = '0;  bus.b = '0;  bus.out_ready = 1'b1;
    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
